// File: rtl/rs5_plic.sv
// rs5_plic: single-context (machine mode) platform-level interrupt controller.
// Level requests are latched as pending by a per-source gateway, arbitrated by
// priority against a threshold, and handed to the CPU through claim/complete.
// Internal per-source vectors are 32 bits wide, indexed directly by source ID;
// bit 0 and bits above i_cnt are held at zero by SRC_MASK.
module rs5_plic #(
  parameter int i_cnt = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [23:0]      addr_i,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  input  logic [i_cnt:1]   irq_i,
  input  logic             iack_i,
  output logic [i_cnt:1]   iack_o,
  output logic             irq_o
);

  // Word addresses (byte offset >> 2) of the fixed registers
  localparam logic [21:0] W_PEND  = 22'h000400;
  localparam logic [21:0] W_EN    = 22'h000800;
  localparam logic [21:0] W_THR   = 22'h080000;
  localparam logic [21:0] W_CLAIM = 22'h080001;

  // Bits 1..i_cnt set: the implemented source IDs
  localparam logic [31:0] SRC_MASK = ((32'h1 << (i_cnt + 1)) - 32'h1) & ~32'h1;

  logic [2:0]  prio_q [32];
  logic [31:0] enable_q;
  logic [2:0]  thresh_q;
  logic [31:0] pending_q;
  logic [31:0] inflight_q;

  logic [31:0] pend_nxt;
  logic [31:0] infl_nxt;
  logic [31:0] irq_w;
  logic [31:0] cand;
  logic [31:0] lane_mask;
  logic [31:0] en_wval;
  logic [31:0] rd_val;
  logic [31:0] iack_nxt;
  logic [21:0] word;
  logic [9:0]  prio_idx;
  logic [4:0]  prio_sel;
  logic [4:0]  cid;
  logic [4:0]  max_id;
  logic [2:0]  best_prio;
  logic        wr;
  logic        rd;
  logic        prio_hit;
  logic        claim_rd;
  logic        complete_wr;
  logic        unused_ok;

  assign word        = addr_i[23:2];
  assign wr          = en_i && (we_i != 4'b0000);
  assign rd          = en_i && (we_i == 4'b0000);
  assign prio_idx    = word[9:0];
  assign prio_sel    = prio_idx[4:0];
  assign prio_hit    = (word[21:10] == '0) && (prio_idx[9:5] == '0) && SRC_MASK[prio_sel];
  assign claim_rd    = rd && (word == W_CLAIM);
  assign complete_wr = wr && (word == W_CLAIM);
  assign cid         = data_i[4:0];
  assign irq_w       = 32'({irq_i, 1'b0});
  assign cand        = pending_q & enable_q & SRC_MASK;
  assign lane_mask   = {{8{we_i[3]}}, {8{we_i[2]}}, {8{we_i[1]}}, {8{we_i[0]}}};
  assign en_wval     = ((enable_q & ~lane_mask) | (data_i & lane_mask)) & SRC_MASK;
  assign iack_nxt    = iack_i ? (32'h1 << max_id) : '0;
  assign unused_ok   = ^{addr_i[1:0], iack_nxt};

  // Arbitration: strict '>' while scanning upward makes ties go to the lowest ID;
  // seeding with the threshold enforces priority > threshold.
  always_comb begin
    best_prio = thresh_q;
    max_id    = '0;
    for (int unsigned k = 1; k < 32; k++) begin
      if (cand[k] && (prio_q[k] > best_prio)) begin
        best_prio = prio_q[k];
        max_id    = 5'(k);
      end
    end
  end

  // Read data multiplexer
  always_comb begin
    rd_val = '0;
    if (prio_hit) begin
      rd_val = 32'(prio_q[prio_sel]);
    end else if (word == W_PEND) begin
      rd_val = pending_q;
    end else if (word == W_EN) begin
      rd_val = enable_q;
    end else if (word == W_THR) begin
      rd_val = 32'(thresh_q);
    end else if (word == W_CLAIM) begin
      rd_val = 32'(max_id);
    end
  end

  // Gateway, claim and complete. Claim is applied after the gateway set so a
  // claimed source ends inflight rather than pending; the gateway sees the old
  // inflight so a completed source re-pends one cycle after the complete.
  always_comb begin
    pend_nxt = (pending_q | (irq_w & ~inflight_q)) & SRC_MASK;
    infl_nxt = inflight_q;
    if (claim_rd && (max_id != '0)) begin
      pend_nxt[max_id] = 1'b0;
      infl_nxt[max_id] = 1'b1;
    end
    if (complete_wr && SRC_MASK[cid]) begin
      infl_nxt[cid] = 1'b0;
    end
  end

  // Configuration registers: priorities, enable, threshold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 32; k++) begin
        prio_q[k] <= '0;
      end
      enable_q <= '0;
      thresh_q <= '0;
    end else if (wr) begin
      if (prio_hit && we_i[0]) begin
        prio_q[prio_sel] <= data_i[2:0];
      end
      if (word == W_EN) begin
        enable_q <= en_wval;
      end
      if ((word == W_THR) && we_i[0]) begin
        thresh_q <= data_i[2:0];
      end
    end
  end

  // Pending and inflight state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      pending_q  <= pend_nxt;
      inflight_q <= infl_nxt;
    end
  end

  // Registered outputs: read data (held between reads), CPU request, acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o <= '0;
      irq_o  <= 1'b0;
      iack_o <= '0;
    end else begin
      if (rd) begin
        data_o <= rd_val;
      end
      irq_o  <= (max_id != '0);
      iack_o <= iack_nxt[i_cnt:1];
    end
  end

endmodule

// File: tb/tb_rs5_plic.sv
// Testbench for rs5_plic: table-driven register checks, directed claim/complete
// and acknowledge sequences, then random traffic against a behavioural model.
module tb_rs5_plic;

  localparam int N = 5;

  localparam logic [23:0] A_PEND  = 24'h001000;
  localparam logic [23:0] A_EN    = 24'h002000;
  localparam logic [23:0] A_THR   = 24'h200000;
  localparam logic [23:0] A_CLAIM = 24'h200004;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en_i;
  logic [3:0]    we_i;
  logic [23:0]   addr_i;
  logic [31:0]   data_i;
  logic [31:0]   data_o;
  logic [N:1]    irq_i;
  logic          iack_i;
  logic [N:1]    iack_o;
  logic          irq_o;

  int checks   = 0;
  int failures = 0;

  rs5_plic #(.i_cnt(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .irq_i   (irq_i),
    .iack_i  (iack_i),
    .iack_o  (iack_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  int unsigned m_prio [32];
  bit          m_en   [32];
  bit          m_pend [32];
  bit          m_infl [32];
  int unsigned m_thr;
  logic [31:0] m_data;
  bit          m_irq;
  logic [N:1]  m_iack;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0; m_infl[i] = 0;
    end
    m_thr = 0; m_data = '0; m_irq = 0; m_iack = '0;
  endfunction

  function automatic bit eligible(int id);
    return m_pend[id] && m_en[id] && (m_prio[id] > m_thr);
  endfunction

  // Highest priority among eligible sources, then the lowest ID holding it.
  function automatic int m_winner();
    int unsigned top = 0;
    for (int id = 1; id <= N; id++)
      if (eligible(id) && m_prio[id] > top) top = m_prio[id];
    if (top == 0) return 0;
    for (int id = 1; id <= N; id++)
      if (eligible(id) && m_prio[id] == top) return id;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(logic [23:0] addr);
    logic [23:0] a = addr & 24'hFFFFFC;
    logic [31:0] v = '0;
    int id;
    if (a < 24'h001000) begin
      id = int'(a) / 4;
      if (id >= 1 && id <= N) v = 32'(m_prio[id]);
    end else if (a == A_PEND) begin
      for (int b = 1; b <= N; b++) v[b] = m_pend[b];
    end else if (a == A_EN) begin
      for (int b = 1; b <= N; b++) v[b] = m_en[b];
    end else if (a == A_THR) begin
      v = 32'(m_thr);
    end else if (a == A_CLAIM) begin
      v = 32'(m_winner());
    end
    return v;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void m_step();
    int w = m_winner();
    bit rd = en_i && (we_i == 4'b0000);
    bit wr = en_i && (we_i != 4'b0000);
    logic [23:0] a = addr_i & 24'hFFFFFC;
    bit old_infl [32];
    int id;
    if (rd) m_data = m_read(addr_i);
    m_irq  = (w != 0);
    m_iack = '0;
    if (iack_i && w != 0) m_iack[w] = 1'b1;
    old_infl = m_infl;
    for (int k = 1; k <= N; k++)
      if (irq_i[k] && !old_infl[k]) m_pend[k] = 1;
    if (rd && a == A_CLAIM && w != 0) begin
      m_pend[w] = 0;
      m_infl[w] = 1;
    end
    if (wr) begin
      if (a == A_CLAIM) begin
        id = int'(data_i & 32'h1F);
        if (id >= 1 && id <= N) m_infl[id] = 0;
      end else if (a < 24'h001000) begin
        id = int'(a) / 4;
        if (id >= 1 && id <= N && we_i[0]) m_prio[id] = int'(data_i & 32'h7);
      end else if (a == A_EN) begin
        for (int b = 1; b <= N; b++)
          if (we_i[b / 8]) m_en[b] = data_i[b];
      end else if (a == A_THR) begin
        if (we_i[0]) m_thr = int'(data_i & 32'h7);
      end
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_i = 1'b0; we_i = 4'b0000;
  endtask

  task automatic bus_wr(logic [23:0] a, logic [31:0] d, logic [3:0] we);
    en_i = 1'b1; we_i = we; addr_i = a; data_i = d;
    tick();
    idle();
  endtask

  task automatic bus_rd(logic [23:0] a, output logic [31:0] d);
    en_i = 1'b1; we_i = 4'b0000; addr_i = a;
    tick();
    d = data_o;
    idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_reset();
    #1;
    check("reset data_o", data_o, 32'h0);
    check("reset irq_o", 32'(irq_o), 32'h0);
    check("reset iack_o", 32'(iack_o), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic model_check(string tag);
    check({tag, " data_o"}, data_o, m_data);
    check({tag, " irq_o"}, 32'(irq_o), 32'(m_irq));
    check({tag, " iack_o"}, 32'(iack_o), 32'(m_iack));
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam logic [31:0] EN_ALL = ((32'h1 << (N + 1)) - 32'h1) & ~32'h1;

  vec_t tbl [14];
  logic [31:0] rv;

  initial begin
    reset_n = 1'b0; idle(); addr_i = '0; data_i = '0; irq_i = '0; iack_i = 1'b0;
    m_reset();
    @(posedge clk); #1;
    do_reset();

    // 1. reset state of every register
    for (int id = 0; id <= N + 2; id++) begin
      bus_rd(24'(4 * id), rv);
      check($sformatf("reset prio[%0d]", id), rv, 32'h0);
    end
    bus_rd(A_PEND, rv);  check("reset pending", rv, 32'h0);
    bus_rd(A_EN, rv);    check("reset enable", rv, 32'h0);
    bus_rd(A_THR, rv);   check("reset threshold", rv, 32'h0);
    bus_rd(A_CLAIM, rv); check("reset claim", rv, 32'h0);
    irq_i = '1;
    tick();
    iack_i = 1'b1; tick(); iack_i = 1'b0;
    check("disabled irq_o", 32'(irq_o), 32'h0);
    check("disabled iack_o", 32'(iack_o), 32'h0);
    tick();
    check("disabled irq_o later", 32'(irq_o), 32'h0);
    irq_i = '0;
    do_reset();

    // Register write/readback table, including byte lanes and unmapped IDs
    tbl[0]  = '{24'h000004, 4'hF, 32'hFFFFFFFD, 32'h5};
    tbl[1]  = '{24'h000014, 4'hF, 32'h00000003, 32'h3};
    tbl[2]  = '{24'h000000, 4'hF, 32'h00000007, 32'h0};
    tbl[3]  = '{24'(4 * (N + 1)), 4'hF, 32'h00000007, 32'h0};
    tbl[4]  = '{24'h000100, 4'hF, 32'h00000007, 32'h0};
    tbl[5]  = '{A_EN,       4'h1, 32'hFFFFFFFF, EN_ALL & 32'hFF};
    tbl[6]  = '{A_EN,       4'h2, 32'h00000000, EN_ALL & 32'hFF};
    tbl[7]  = '{A_EN,       4'hF, 32'h00000000, 32'h0};
    tbl[8]  = '{A_THR,      4'h2, 32'h00000007, 32'h0};
    tbl[9]  = '{A_THR,      4'h1, 32'hFFFFFFF6, 32'h6};
    tbl[10] = '{A_PEND,     4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[11] = '{24'h003000, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[12] = '{A_THR,      4'hF, 32'h00000000, 32'h0};
    tbl[13] = '{24'h000007, 4'hF, 32'h00000002, 32'h2};
    for (int i = 0; i < 14; i++) begin
      bus_wr(tbl[i].addr, tbl[i].wdata, tbl[i].we);
      bus_rd(tbl[i].addr, rv);
      check($sformatf("table[%0d] @%06h", i, tbl[i].addr), rv, tbl[i].exp);
    end
    bus_wr(24'h000014, 32'h0, 4'hF);

    // 2. source 1 pulse, claim
    bus_wr(24'h000004, 32'h3, 4'hF);
    bus_wr(A_EN, 32'h2, 4'hF);
    bus_wr(A_THR, 32'h0, 4'hF);
    irq_i[1] = 1'b1; tick(); irq_i[1] = 1'b0;
    check("s2 irq_o latency", 32'(irq_o), 32'h0);
    bus_rd(A_PEND, rv);
    check("s2 pending", rv, 32'h2);
    check("s2 irq_o", 32'(irq_o), 32'h1);
    bus_rd(A_CLAIM, rv);
    check("s2 claim", rv, 32'h1);
    bus_rd(A_PEND, rv);
    check("s2 pending after claim", rv, 32'h0);
    check("s2 irq_o dropped", 32'(irq_o), 32'h0);
    bus_wr(A_CLAIM, 32'h1, 4'hF);

    // 3. threshold gating
    bus_wr(24'h000004, 32'h2, 4'hF);
    bus_wr(A_THR, 32'h2, 4'hF);
    irq_i[1] = 1'b1;
    tick(); tick();
    check("s3 irq_o at threshold", 32'(irq_o), 32'h0);
    bus_rd(A_CLAIM, rv);
    check("s3 claim at threshold", rv, 32'h0);
    bus_wr(A_THR, 32'h1, 4'hF);
    tick();
    check("s3 irq_o above threshold", 32'(irq_o), 32'h1);

    // 4. claim with level held, complete re-pends one cycle later
    bus_rd(A_CLAIM, rv);
    check("s4 claim", rv, 32'h1);
    bus_rd(A_PEND, rv);
    check("s4 pending inflight", rv, 32'h0);
    bus_wr(A_CLAIM, 32'h7, 4'hF);
    bus_rd(A_PEND, rv);
    check("s4 complete 7 ignored", rv, 32'h0);
    check("s4 irq_o still low", 32'(irq_o), 32'h0);
    bus_wr(A_CLAIM, 32'h1, 4'hF);
    bus_rd(A_PEND, rv);
    check("s4 pending first cycle", rv, 32'h0);
    bus_rd(A_PEND, rv);
    check("s4 pending re-set", rv, 32'h2);
    check("s4 irq_o again", 32'(irq_o), 32'h1);

    // 5. acknowledge pulse
    iack_i = 1'b1; tick(); iack_i = 1'b0;
    check("s5 iack_o pulse", 32'(iack_o), 32'h1);
    tick();
    check("s5 iack_o one cycle", 32'(iack_o), 32'h0);
    bus_rd(A_PEND, rv);
    check("s5 pending unchanged", rv, 32'h2);

    // Tie between equal priorities goes to the lowest ID
    bus_wr(24'h000008, 32'h4, 4'hF);
    bus_wr(24'h00000C, 32'h4, 4'hF);
    bus_wr(A_EN, 32'hE, 4'hF);
    irq_i = 5'b00110;
    tick();
    bus_rd(A_CLAIM, rv);
    check("tie claim", rv, 32'h2);
    bus_rd(A_CLAIM, rv);
    check("tie second claim", rv, 32'h3);
    irq_i = '0;

    // Random traffic against the model, with an asynchronous reset midway
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int op = $urandom_range(0, 9);
      int k  = $urandom_range(0, 12);
      logic [23:0] a;
      if (i == 1500) begin
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        model_check("async reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
      end
      if (k < 8)       a = 24'(4 * k);
      else if (k == 8) a = A_PEND;
      else if (k == 9) a = A_EN;
      else if (k == 10) a = A_THR;
      else if (k == 11) a = A_CLAIM;
      else             a = 24'h000100;
      addr_i = a | 24'($urandom_range(0, 3));
      en_i   = (op >= 4);
      we_i   = (op >= 7) ? 4'((($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 15)) : 4'h0;
      data_i = (k == 11) ? 32'($urandom_range(0, 7)) : $urandom;
      for (int b = 1; b <= N; b++)
        if ($urandom_range(0, 7) == 0) irq_i[b] = ~irq_i[b];
      iack_i = ($urandom_range(0, 7) == 0);
      tick();
      model_check($sformatf("rand[%0d]", i));
    end
    idle();
    iack_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
